// File: rtl/axis_stat_poller.sv
// Periodic/manual sweep controller: triggers each statistics counter in turn
// and forwards its status frame onto a single merged AXI-Stream output.
module axis_stat_poller #(
    parameter int PORTS        = 4,
    parameter int TAG_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [PERIOD_WIDTH-1:0]    period,
    input  logic                       poll_now,
    input  logic [TAG_WIDTH-1:0]       base_tag,
    output logic [PORTS-1:0]           stat_trigger,
    output logic [PORTS*TAG_WIDTH-1:0] stat_tag,
    input  logic [PORTS-1:0]           stat_busy,
    input  logic [PORTS*8-1:0]         s_axis_tdata,
    input  logic [PORTS-1:0]           s_axis_tvalid,
    input  logic [PORTS-1:0]           s_axis_tlast,
    output logic [PORTS-1:0]           s_axis_tready,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic                       sweep_busy,
    output logic                       overrun,
    output logic [15:0]                sweep_count
);

    localparam int SEL_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(PORTS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, TRIG, FWD} state_t;

    state_t                  state;
    logic [SEL_W-1:0]        sel;
    logic [PERIOD_WIDTH-1:0] timer;
    logic                    sweep_pending;
    logic                    timer_on;
    logic                    timer_fire;
    logic                    sweep_req;
    logic                    sel_busy;
    logic                    fwd_last;

    assign timer_on   = enable && (period != '0);
    assign timer_fire = timer_on && (timer == period);
    assign sweep_req  = timer_fire || poll_now;

    for (genvar g = 0; g < PORTS; g++) begin : g_tag
        assign stat_tag[g*TAG_WIDTH +: TAG_WIDTH] = base_tag + TAG_WIDTH'(g);
    end

    // Zero-latency path from the selected counter to the merged stream.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        sel_busy      = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_busy = stat_busy[i];
                if (state == FWD) begin
                    m_axis_tdata     = s_axis_tdata[i*8 +: 8];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    m_axis_tlast     = s_axis_tlast[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    assign fwd_last = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            timer <= '0;
        end else if (!timer_on) begin
            timer <= '0;
        end else if (timer_fire) begin
            timer <= PERIOD_WIDTH'(1);
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sel           <= '0;
            sweep_pending <= 1'b0;
            overrun       <= 1'b0;
            sweep_count   <= '0;
            stat_trigger  <= '0;
            sweep_busy    <= 1'b0;
        end else begin
            stat_trigger <= '0;
            if (sweep_req && sweep_busy && sweep_pending) begin
                overrun <= 1'b1;
            end
            // A request landing on the IDLE->WAIT edge keeps pending set for one more sweep.
            if (sweep_req) begin
                sweep_pending <= 1'b1;
            end else if (state == IDLE && sweep_pending) begin
                sweep_pending <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (sweep_pending) begin
                        sel        <= '0;
                        state      <= WAIT;
                        sweep_busy <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!sel_busy) begin
                        state        <= TRIG;
                        stat_trigger <= PORTS'(1) << sel;
                    end
                end
                TRIG: state <= FWD;
                FWD: begin
                    if (fwd_last) begin
                        if (sel == LAST_SEL) begin
                            state       <= IDLE;
                            sweep_busy  <= 1'b0;
                            sweep_count <= sweep_count + 16'd1;
                        end else begin
                            sel   <= sel + 1'b1;
                            state <= WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_stat_poller.sv
// Randomized bench for axis_stat_poller: behavioural counters plus an
// in-order scoreboard of the merged status stream.
module tb_axis_stat_poller;

    localparam int PORTS        = 4;
    localparam int TAG_WIDTH    = 16;
    localparam int PERIOD_WIDTH = 32;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       enable;
    logic [PERIOD_WIDTH-1:0]    period;
    logic                       poll_now;
    logic [TAG_WIDTH-1:0]       base_tag;
    logic [PORTS-1:0]           stat_trigger;
    logic [PORTS*TAG_WIDTH-1:0] stat_tag;
    logic [PORTS-1:0]           stat_busy;
    logic [PORTS*8-1:0]         s_axis_tdata;
    logic [PORTS-1:0]           s_axis_tvalid;
    logic [PORTS-1:0]           s_axis_tlast;
    logic [PORTS-1:0]           s_axis_tready;
    logic [7:0]                 m_axis_tdata;
    logic                       m_axis_tvalid;
    logic                       m_axis_tlast;
    logic                       m_axis_tready;
    logic                       sweep_busy;
    logic                       overrun;
    logic [15:0]                sweep_count;

    always #5 clk = ~clk;

    axis_stat_poller #(
        .PORTS(PORTS), .TAG_WIDTH(TAG_WIDTH), .PERIOD_WIDTH(PERIOD_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
        .poll_now(poll_now), .base_tag(base_tag),
        .stat_trigger(stat_trigger), .stat_tag(stat_tag), .stat_busy(stat_busy),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .sweep_busy(sweep_busy), .overrun(overrun), .sweep_count(sweep_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: counters hold {tlast,data} frames; exp_q is the merged order.
    logic [8:0]       cq [PORTS][$];
    logic [8:0]       exp_q[$];
    logic [8:0]       ent;
    logic [PORTS-1:0] trig;
    bit               in_fwd      = 0;
    int               fwd_port    = 0;
    int               next_port   = 0;
    int               frames_done = 0;
    int               nbytes      = 0;
    int               nlast       = 0;
    int               trig_total  = 0;
    int               trig_cyc[PORTS];
    int               trig_cnt[PORTS];
    int               frame_len   = 14;
    int               tready_mode = 0;
    int               len;

    initial begin
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < PORTS; i++) begin
            trig_cyc[i] = 0;
            trig_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < PORTS; i++) cq[i].delete();
                exp_q.delete();
                in_fwd      = 0;
                next_port   = 0;
                frames_done = 0;
            end else begin
                trig = stat_trigger;
                if (in_fwd) begin
                    check("s_tready_fwd", s_axis_tready, PORTS'(m_axis_tready) << fwd_port);
                    check("m_tvalid_fwd", m_axis_tvalid, s_axis_tvalid[fwd_port]);
                    check("busy_fwd", sweep_busy, 1);
                end else begin
                    check("s_tready_off", s_axis_tready, 0);
                    check("m_tvalid_off", m_axis_tvalid, 0);
                end
                for (int i = 0; i < PORTS; i++) begin
                    if (s_axis_tvalid[i] && s_axis_tready[i] && cq[i].size() > 0)
                        void'(cq[i].pop_front());
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    nbytes++;
                    if (m_axis_tlast) nlast++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 1, 0);
                    end else begin
                        ent = exp_q.pop_front();
                        check("m_tdata", m_axis_tdata, ent[7:0]);
                        check("m_tlast", m_axis_tlast, ent[8]);
                    end
                    if (m_axis_tlast) begin
                        in_fwd = 0;
                        frames_done++;
                    end
                end
                if (trig != '0) begin
                    check("trig_port", trig, PORTS'(1) << next_port);
                    check("stat_tag", stat_tag[next_port*TAG_WIDTH +: TAG_WIDTH],
                          TAG_WIDTH'(base_tag + next_port));
                    trig_cyc[next_port] = cyc;
                    trig_cnt[next_port]++;
                    trig_total++;
                    len = (frame_len > 0) ? frame_len : $urandom_range(1, 8);
                    for (int b = 0; b < len; b++) begin
                        ent = {b == len - 1, 8'($urandom)};
                        cq[next_port].push_back(ent);
                        exp_q.push_back(ent);
                    end
                    in_fwd    = 1;
                    fwd_port  = next_port;
                    next_port = (next_port + 1) % PORTS;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < PORTS; i++) begin
                if (cq[i].size() > 0) begin
                    s_axis_tvalid[i]       = 1'b1;
                    s_axis_tdata[i*8 +: 8] = cq[i][0][7:0];
                    s_axis_tlast[i]        = cq[i][0][8];
                end else begin
                    s_axis_tvalid[i]       = 1'b0;
                    s_axis_tdata[i*8 +: 8] = 8'h00;
                    s_axis_tlast[i]        = 1'b0;
                end
            end
            case (tready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom);
            endcase
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_poll();
        cycle();
        poll_now = 1'b1;
        cycle();
        poll_now = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            cycle();
            n++;
        end
        check("frames_reached", frames_done >= target, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    int c0, t_first, f0, b0, l0, k1, fall, t0, n;

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        period    = '0;
        poll_now  = 1'b0;
        base_tag  = 16'hFFFE;
        stat_busy = '0;
        #12;
        check("rst_trigger", stat_trigger, 0);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_sweep_busy", sweep_busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_sweep_count", sweep_count, 0);
        for (int i = 0; i < PORTS; i++)
            check("tag_wrap", stat_tag[i*TAG_WIDTH +: TAG_WIDTH], TAG_WIDTH'(32'hFFFE + i));
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();

        // Timer-driven sweeps, 14-byte frames, tready held high.
        b0     = nbytes;
        l0     = nlast;
        period = 100;
        enable = 1'b1;
        c0     = cyc;
        wait_frames(1, 300);
        t_first = trig_cyc[0];
        check("timer_first", (t_first >= c0 + 100) && (t_first <= c0 + 105), 1);
        wait_frames(4, 200);
        repeat (2) cycle();
        check("sweep1_count", sweep_count, 1);
        check("sweep1_bytes", nbytes - b0, 56);
        check("sweep1_tlast", nlast - l0, 4);
        check("sweep1_idle", sweep_busy, 0);
        wait_frames(5, 300);
        check("timer_spacing", trig_cyc[0] - t_first, 100);
        wait_frames(8, 200);
        enable = 1'b0;
        repeat (2) cycle();
        check("sweep2_count", sweep_count, 2);

        // Port 1 busy for 20 cycles once it is reached.
        f0        = frames_done;
        k1        = trig_cnt[1];
        stat_busy = 4'b0010;
        pulse_poll();
        wait_frames(f0 + 1, 200);
        repeat (20) cycle();
        check("no_early_trig1", trig_cnt[1], k1);
        stat_busy = '0;
        fall      = cyc;
        wait_frames(f0 + PORTS, 300);
        check("trig1_after_busy", trig_cyc[1], fall + 1);
        check("trig1_once", trig_cnt[1] - k1, 1);

        // Random frame lengths, busy, tags and output backpressure.
        for (int s = 0; s < 6; s++) begin
            frame_len   = 0;
            tready_mode = (s < 3) ? 1 : 2;
            f0          = frames_done;
            base_tag    = 16'($urandom);
            stat_busy   = PORTS'($urandom);
            pulse_poll();
            n = $urandom_range(0, 10);
            for (int j = 0; j < n; j++) begin
                base_tag = 16'($urandom);
                cycle();
            end
            stat_busy = '0;
            wait_frames(f0 + PORTS, 500);
            repeat (3) cycle();
            check("rand_sweep_count", sweep_count, 16'(frames_done / PORTS));
            check("rand_idle", sweep_busy, 0);
        end

        // Three requests during one sweep merge into a single extra sweep.
        tready_mode = 0;
        frame_len   = 14;
        check("overrun_before", overrun, 0);
        f0 = frames_done;
        pulse_poll();
        wait_frames(f0 + 1, 200);
        for (int j = 0; j < 3; j++) begin
            pulse_poll();
            repeat (2) cycle();
        end
        wait_frames(f0 + 2 * PORTS, 600);
        repeat (150) cycle();
        check("one_extra_sweep", frames_done, f0 + 2 * PORTS);
        check("overrun_set", overrun, 1);

        // period == 0 disables the timer; poll_now still works.
        enable = 1'b1;
        period = '0;
        t0     = trig_total;
        repeat (300) cycle();
        check("period0_no_sweep", trig_total, t0);
        f0 = frames_done;
        pulse_poll();
        wait_frames(f0 + PORTS, 300);
        repeat (50) cycle();
        check("period0_one_sweep", frames_done, f0 + PORTS);
        check("period0_count", sweep_count, 16'(frames_done / PORTS));
        enable = 1'b0;

        // Asynchronous reset in the middle of port 2's frame.
        pulse_poll();
        n = 0;
        while (!(in_fwd && fwd_port == 2) && n < 300) begin
            cycle();
            n++;
        end
        check("reached_port2", in_fwd && fwd_port == 2, 1);
        repeat (4) cycle();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_m_tvalid", m_axis_tvalid, 0);
        check("arst_s_tready", s_axis_tready, 0);
        check("arst_trigger", stat_trigger, 0);
        check("arst_sweep_busy", sweep_busy, 0);
        check("arst_sweep_count", sweep_count, 0);
        check("arst_overrun", overrun, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t0 = trig_total;
        repeat (50) cycle();
        check("post_rst_no_trig", trig_total, t0);
        check("post_rst_idle", sweep_busy, 0);
        check("post_rst_m_tvalid", m_axis_tvalid, 0);
        pulse_poll();
        wait_frames(PORTS, 300);
        repeat (3) cycle();
        check("post_rst_count", sweep_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
